// File: rtl/mult_div_if.sv
// Handshake and HI/LO bus between pipeline control and the multiply/divide unit.
interface mult_div_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide on magnitudes,
// signs fixed up in FINISH; owns the architectural HI/LO registers.
module mult_div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_div_if.slave  bus_io
);
  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntInit = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e                state_q, state_d;
  logic [1:0]            op_q;
  logic                  sign_a_q, sign_b_q;
  logic [DATA_W-1:0]     opd_q;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_W-1:0]     hi_q, lo_q;
  logic                  done_q, done_d;
  logic                  dbz_q, dbz_d;

  logic                  req_div, req_signed, div_zero, accept;
  logic [DATA_W-1:0]     a_abs, b_abs;
  logic [DATA_W:0]       mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quo, rem, res_hi, res_lo;

  always_comb begin
    req_div    = bus_io.op[1];
    req_signed = ~bus_io.op[0];
    a_abs      = (req_signed && bus_io.operand_a[DATA_W-1]) ? -bus_io.operand_a
                                                            : bus_io.operand_a;
    b_abs      = (req_signed && bus_io.operand_b[DATA_W-1]) ? -bus_io.operand_b
                                                            : bus_io.operand_b;
    div_zero   = (state_q == StIdle) && bus_io.start && req_div && (bus_io.operand_b == '0);
    accept     = (state_q == StIdle) && bus_io.start && !div_zero;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StCalc;
      StCalc:   if (cnt_q == '0) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic; done/div_by_zero are registered single-cycle pulses
  always_comb begin
    bus_io.busy = (state_q != StIdle);
    done_d      = 1'b0;
    dbz_d       = 1'b0;
    case (state_q)
      StIdle: begin
        done_d = div_zero;
        dbz_d  = div_zero;
      end
      StFinish: done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus_io.done        = done_q;
  assign bus_io.div_by_zero = dbz_q;
  assign bus_io.hi          = hi_q;
  assign bus_io.lo          = lo_q;

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opd_q};
    if (!op_q[1]) begin
      acc_d = {mul_sum, acc_q[DATA_W-1:1]};
    end else if (!div_diff[DATA_W]) begin
      acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end else begin
      acc_d = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end
  end

  // Sign fix-up; remainder follows the dividend, so -2^31 / -1 wraps to 0x80000000 naturally
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo      = acc_q[DATA_W-1:0];
    rem      = acc_q[2*DATA_W-1:DATA_W];
    if (op_q[1]) begin
      res_lo = (sign_a_q ^ sign_b_q) ? -quo : quo;
      res_hi = sign_a_q ? -rem : rem;
    end else begin
      res_lo = prod_fix[DATA_W-1:0];
      res_hi = prod_fix[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 2'b00;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= done_d;
      dbz_q  <= dbz_d;
      if (accept) begin
        op_q     <= bus_io.op;
        sign_a_q <= req_signed & bus_io.operand_a[DATA_W-1];
        sign_b_q <= req_signed & bus_io.operand_b[DATA_W-1];
        opd_q    <= req_div ? b_abs : a_abs;
        acc_q    <= {{DATA_W{1'b0}}, (req_div ? a_abs : b_abs)};
        cnt_q    <= CntInit;
      end else if (state_q == StCalc) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  // Move writes only land while idle; a finishing op owns HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == StFinish) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (state_q == StIdle) begin
      if (bus_io.hi_we) hi_q <= bus_io.wdata;
      if (bus_io.lo_we) lo_q <= bus_io.wdata;
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected {div_by_zero, hi, lo} queued at start, checked at done.
module tb_mult_div_unit;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_div_if #(.DATA_W(W)) bus ();

  mult_div_unit #(.DATA_W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  int unsigned     tests = 0;
  int unsigned     fails = 0;
  logic [64:0]     sb_q[$];
  logic [W-1:0]    mdl_hi = '0;
  logic [W-1:0]    mdl_lo = '0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results straight from SV arithmetic
  function automatic logic [64:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] chi,
                                        input logic [W-1:0] clo);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic [W-1:0]       q, r;
    if (op[1] && b == '0) return {1'b1, chi, clo};
    case (op)
      2'b00: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return {1'b0, sp};
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        return {1'b0, up};
      end
      2'b10: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = '0;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
        end
        return {1'b0, r, q};
      end
      default: return {1'b0, a % b, a / b};
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [64:0] e;
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    e = model(op, a, b, mdl_hi, mdl_lo);
    sb_q.push_back(e);
    mdl_hi = e[63:32];
    mdl_lo = e[31:0];
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int          cyc = 0;
    int          busy_bad = 0;
    logic [64:0] e;
    while (!bus.done && cyc < 40) begin
      if (bus.busy !== 1'b1) busy_bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, 65'(cyc), 65'(exp_lat));
    check({tag, " busy_held"}, 65'(busy_bad), 65'd0);
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 65'(sb_q.size()), 65'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, " result"}, {bus.div_by_zero, bus.hi, bus.lo}, e);
    end
    check({tag, " busy_at_done"}, 65'(bus.busy), 65'd0);
    @(posedge clk);
    #1;
    check({tag, " pulse_end"}, {63'd0, bus.done, bus.div_by_zero}, 65'd0);
  endtask

  initial begin
    int ndone;
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    rst_n = 1'b0;
    #12;
    check("reset", {bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo}, 65'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 33);
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg", 33);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 33);
    issue(2'b11, 32'd7, 32'd2);
    wait_done("divu", 33);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_negdivisor", 33);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_minmin", 33);

    // Move writes, then divide by zero must leave them alone
    bus.hi_we = 1'b1; bus.wdata = 32'h11;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h22;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    mdl_hi = 32'h11; mdl_lo = 32'h22;
    check("mthi_mtlo", {1'b0, bus.hi, bus.lo}, {1'b0, 32'h11, 32'h22});
    issue(2'b10, 32'd100, 32'd0);
    wait_done("div_zero", 0);
    issue(2'b11, 32'd5, 32'd0);
    wait_done("divu_zero", 0);

    // Start while busy is ignored
    issue(2'b01, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd9; bus.operand_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("ignored_start", 28);

    // Move write coinciding with start; the product later overwrites
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
    issue(2'b01, 32'd3, 32'd4);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("mt_with_start", {1'b0, bus.hi, bus.lo}, {1'b0, 32'hABCD, 32'hABCD});
    wait_done("mt_overwritten", 33);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_overflow", 33);

    // Reset mid-operation
    issue(2'b01, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midop_reset", {bus.busy, bus.done, bus.hi, bus.lo}, 65'd0);
    void'(sb_q.pop_front());
    mdl_hi = '0; mdl_lo = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) ndone++;
    end
    check("no_done_after_reset", 65'(ndone), 65'd0);
    check("scoreboard_drained", 65'(sb_q.size()), 65'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
